// File: rtl/ras_ckpt.sv
// Return address stack with pointer/count checkpoint restore for the fetch predictor.
// Optional top-entry repair on restore is enabled by defining RAS_TOP_REPAIR_EN.
module ras_ckpt #(
   parameter int RAS_DEPTH        = 8,
   parameter int RAS_TARGET_WIDTH = 14,
   parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        push_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] push_target,
   input  logic                        pop_valid,
   output logic [RAS_TARGET_WIDTH-1:0] ras_top_target,
   output logic                        ras_top_valid,
   output logic [LOG_RAS_DEPTH-1:0]    ras_ptr,
   output logic [LOG_RAS_DEPTH:0]      ras_count,
   input  logic                        restore_valid,
   input  logic [LOG_RAS_DEPTH-1:0]    restore_ptr,
   input  logic [LOG_RAS_DEPTH:0]      restore_count,
   input  logic [RAS_TARGET_WIDTH-1:0] restore_target,
   output logic                        ras_overflow
);

   localparam logic [LOG_RAS_DEPTH:0] DEPTH_C = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);
   localparam logic [LOG_RAS_DEPTH:0] ONE_C   = (LOG_RAS_DEPTH+1)'(1);

   logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_DEPTH];
   logic [LOG_RAS_DEPTH-1:0]    ptr_q, ptr_d, ptr_inc;
   logic [LOG_RAS_DEPTH:0]      count_q, count_d;
   logic                        ovf_q, ovf_d;
   logic                        wr_en;
   logic [LOG_RAS_DEPTH-1:0]    wr_idx;
   logic [RAS_TARGET_WIDTH-1:0] wr_data;

   assign ptr_inc = ptr_q + 1'b1;

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      wr_data = push_target;
      if (restore_valid) begin
         ptr_d   = restore_ptr;
         count_d = (restore_count > DEPTH_C) ? DEPTH_C : restore_count;
`ifdef RAS_TOP_REPAIR_EN
         // Undo a wrong-path overwrite of the checkpointed top entry.
         wr_en   = 1'b1;
         wr_idx  = restore_ptr;
         wr_data = restore_target;
`endif
      end else if (push_valid && pop_valid) begin
         wr_en = 1'b1;
         if (count_q == '0) count_d = ONE_C;
      end else if (push_valid) begin
         ptr_d  = ptr_inc;
         wr_en  = 1'b1;
         wr_idx = ptr_inc;
         if (count_q == DEPTH_C) ovf_d = 1'b1;
         else                    count_d = count_q + 1'b1;
      end else if (pop_valid && count_q != '0) begin
         ptr_d   = ptr_q - 1'b1;
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         if (wr_en) stack_q[wr_idx] <= wr_data;
      end
   end

   assign ras_top_target = stack_q[ptr_q];
   assign ras_top_valid  = (count_q != '0);
   assign ras_ptr        = ptr_q;
   assign ras_count      = count_q;
   assign ras_overflow   = ovf_q;

endmodule

// File: tb/tb_ras_ckpt.sv
// Table-driven bench for ras_ckpt; expected post-edge state is queued per step and checked after the edge.
module tb_ras_ckpt;

   logic        CLK = 1'b0;
   logic        RST;
   logic        push_valid, pop_valid, restore_valid;
   logic [13:0] push_target, restore_target;
   logic [13:0] ras_top_target;
   logic        ras_top_valid, ras_overflow;
   logic [2:0]  ras_ptr, restore_ptr;
   logic [3:0]  ras_count, restore_count;

   int checks = 0;
   int errors = 0;

   ras_ckpt #(.RAS_DEPTH(8), .RAS_TARGET_WIDTH(14)) dut (
      .CLK(CLK), .RST(RST),
      .push_valid(push_valid), .push_target(push_target), .pop_valid(pop_valid),
      .ras_top_target(ras_top_target), .ras_top_valid(ras_top_valid),
      .ras_ptr(ras_ptr), .ras_count(ras_count),
      .restore_valid(restore_valid), .restore_ptr(restore_ptr),
      .restore_count(restore_count), .restore_target(restore_target),
      .ras_overflow(ras_overflow)
   );

   always #5 CLK = ~CLK;

`ifdef RAS_TOP_REPAIR_EN
   localparam logic [13:0] REST_TOP  = 14'h222;
   localparam logic [13:0] CLAMP_TOP = 14'h5A5;
`else
   localparam logic [13:0] REST_TOP  = 14'h3FF;
   localparam logic [13:0] CLAMP_TOP = 14'h005;
`endif

   typedef struct {
      string       name;
      logic        push;
      logic [13:0] pt;
      logic        pop;
      logic        rv;
      logic [2:0]  rp;
      logic [3:0]  rc;
      logic [13:0] rt;
      logic [2:0]  eptr;
      logic [3:0]  ecnt;
      logic [13:0] etop;
      logic        etv;
      logic        eovf;
   } vec_t;

   typedef struct {
      string       name;
      logic [2:0]  ptr;
      logic [3:0]  cnt;
      logic [13:0] top;
      logic        tv;
      logic        ovf;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic vec_t mk(string n, logic pu, logic [13:0] pt, logic po,
                               logic rv, logic [2:0] rp, logic [3:0] rc, logic [13:0] rt,
                               logic [2:0] ep, logic [3:0] ec, logic [13:0] et,
                               logic etv, logic eo);
      vec_t v;
      v.name = n; v.push = pu; v.pt = pt; v.pop = po; v.rv = rv; v.rp = rp; v.rc = rc;
      v.rt = rt; v.eptr = ep; v.ecnt = ec; v.etop = et; v.etv = etv; v.eovf = eo;
      return v;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, req);
      end
   endtask

   task automatic chk_state(string n, logic [2:0] p, logic [3:0] c, logic [13:0] t,
                            logic tv, logic o);
      chk({n, ".ptr"},   32'(ras_ptr),        32'(p));
      chk({n, ".count"}, 32'(ras_count),      32'(c));
      chk({n, ".top"},   32'(ras_top_target), 32'(t));
      chk({n, ".tv"},    32'(ras_top_valid),  32'(tv));
      chk({n, ".ovf"},   32'(ras_overflow),   32'(o));
   endtask

   task automatic idle_inputs();
      push_valid = 0; pop_valid = 0; restore_valid = 0;
      push_target = '0; restore_ptr = '0; restore_count = '0; restore_target = '0;
   endtask

   task automatic run_vec(vec_t v);
      exp_t e;
      @(negedge CLK);
      push_valid = v.push; push_target = v.pt; pop_valid = v.pop;
      restore_valid = v.rv; restore_ptr = v.rp; restore_count = v.rc; restore_target = v.rt;
      e.name = v.name; e.ptr = v.eptr; e.cnt = v.ecnt; e.top = v.etop; e.tv = v.etv; e.ovf = v.eovf;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL %s: scoreboard empty got 0 expected 1", v.name);
      end else begin
         e = sb.pop_front();
         chk_state(e.name, e.ptr, e.cnt, e.top, e.tv, e.ovf);
      end
   endtask

   initial begin
      //             name      push pt     pop rv rp rc  rt       ptr cnt top      tv ovf
      tbl.push_back(mk("pu101", 1, 14'h101, 0, 0, 0, 0, 0,        1, 1, 14'h101, 1, 0));
      tbl.push_back(mk("pu202", 1, 14'h202, 0, 0, 0, 0, 0,        2, 2, 14'h202, 1, 0));
      tbl.push_back(mk("pu303", 1, 14'h303, 0, 0, 0, 0, 0,        3, 3, 14'h303, 1, 0));
      tbl.push_back(mk("po1",   0, 0,       1, 0, 0, 0, 0,        2, 2, 14'h202, 1, 0));
      tbl.push_back(mk("po2",   0, 0,       1, 0, 0, 0, 0,        1, 1, 14'h101, 1, 0));
      tbl.push_back(mk("po3",   0, 0,       1, 0, 0, 0, 0,        0, 0, 14'h000, 0, 0));
      tbl.push_back(mk("poE",   0, 0,       1, 0, 0, 0, 0,        0, 0, 14'h000, 0, 0));
      for (int i = 1; i <= 7; i++)
         tbl.push_back(mk($sformatf("fill%0d", i), 1, 14'(i), 0, 0, 0, 0, 0,
                          3'(i), 4'(i), 14'(i), 1, 0));
      tbl.push_back(mk("fill8", 1, 14'h008, 0, 0, 0, 0, 0,        0, 8, 14'h008, 1, 0));
      tbl.push_back(mk("fill9", 1, 14'h009, 0, 0, 0, 0, 0,        1, 8, 14'h009, 1, 1));
      tbl.push_back(mk("drn1",  0, 0,       1, 0, 0, 0, 0,        0, 7, 14'h008, 1, 0));
      for (int i = 2; i <= 7; i++)
         tbl.push_back(mk($sformatf("drn%0d", i), 0, 0, 1, 0, 0, 0, 0,
                          3'(8 - i + 1), 4'(8 - i), 14'(8 - i + 1), 1, 0));
      tbl.push_back(mk("drn8",  0, 0,       1, 0, 0, 0, 0,        1, 0, 14'h009, 0, 0));
      tbl.push_back(mk("drn9",  0, 0,       1, 0, 0, 0, 0,        1, 0, 14'h009, 0, 0));
      tbl.push_back(mk("pu044", 1, 14'h044, 0, 0, 0, 0, 0,        2, 1, 14'h044, 1, 0));
      tbl.push_back(mk("pu055", 1, 14'h055, 0, 0, 0, 0, 0,        3, 2, 14'h055, 1, 0));
      tbl.push_back(mk("pp0AA", 1, 14'h0AA, 1, 0, 0, 0, 0,        3, 2, 14'h0AA, 1, 0));
      tbl.push_back(mk("po4",   0, 0,       1, 0, 0, 0, 0,        2, 1, 14'h044, 1, 0));
      tbl.push_back(mk("po5",   0, 0,       1, 0, 0, 0, 0,        1, 0, 14'h009, 0, 0));
      tbl.push_back(mk("pp0BB", 1, 14'h0BB, 1, 0, 0, 0, 0,        1, 1, 14'h0BB, 1, 0));
      tbl.push_back(mk("pu222", 1, 14'h222, 0, 0, 0, 0, 0,        2, 2, 14'h222, 1, 0));
      tbl.push_back(mk("wpPop", 0, 0,       1, 0, 0, 0, 0,        1, 1, 14'h0BB, 1, 0));
      tbl.push_back(mk("wp3FF", 1, 14'h3FF, 0, 0, 0, 0, 0,        2, 2, 14'h3FF, 1, 0));
      tbl.push_back(mk("wp111", 1, 14'h111, 0, 0, 0, 0, 0,        3, 3, 14'h111, 1, 0));
      tbl.push_back(mk("rest",  1, 14'h777, 0, 1, 2, 2, 14'h222,  2, 2, REST_TOP, 1, 0));
      tbl.push_back(mk("clamp", 0, 0,       0, 1, 5, 15, 14'h5A5, 5, 8, CLAMP_TOP, 1, 0));
      tbl.push_back(mk("ovf2",  1, 14'h0CC, 0, 0, 0, 0, 0,        6, 8, 14'h0CC, 1, 1));
      tbl.push_back(mk("hold",  0, 0,       0, 0, 0, 0, 0,        6, 8, 14'h0CC, 1, 0));

      idle_inputs();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 chk_state("reset", 0, 0, 14'h000, 0, 0);
      @(negedge CLK) RST = 1'b0;
      #1 chk_state("postrst", 0, 0, 14'h000, 0, 0);

      foreach (tbl[i]) run_vec(tbl[i]);

      // Asynchronous reset in the middle of a push, with a restore pending.
      @(negedge CLK);
      push_valid = 1; push_target = 14'h0EE;
      restore_valid = 1; restore_ptr = 3; restore_count = 3; restore_target = 14'h123;
      #2 RST = 1'b1;
      #1 chk_state("rstAsync", 0, 0, 14'h000, 0, 0);
      @(posedge CLK);
      #1 chk_state("rstHeld", 0, 0, 14'h000, 0, 0);
      @(negedge CLK);
      idle_inputs();
      RST = 1'b0;
      run_vec(mk("pu0DD", 1, 14'h0DD, 0, 0, 0, 0, 0, 1, 1, 14'h0DD, 1, 0));
      run_vec(mk("po0DD", 0, 0,       1, 0, 0, 0, 0, 0, 0, 14'h000, 0, 0));

      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
